// File: rtl/axi_line_fill.sv
// Cache line refill engine: issues one INCR AXI read burst per miss and streams the returned words to the cache array.
// Latency: AR is issued the cycle after miss; each accepted R beat appears on mem_* one cycle later. Backpressure: honours arready; rready is held high for the whole data phase.
`timescale 1ns/1ps
module axi_line_fill #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int LINE_SIZE_BITS = 7
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    miss,
    input  logic [ADDR_WIDTH-1:0]   miss_addr,
    output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [7:0]              m_axi_arlen,
    output logic [2:0]              m_axi_arsize,
    output logic [1:0]              m_axi_arburst,
    output logic                    m_axi_arvalid,
    input  logic                    m_axi_arready,
    input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]              m_axi_rresp,
    input  logic                    m_axi_rlast,
    input  logic                    m_axi_rvalid,
    output logic                    m_axi_rready,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_data,
    output logic [DATA_WIDTH/8-1:0] mem_wstb,
    output logic                    mem_data_valid,
    output logic                    mem_last,
    output logic                    fill_busy,
    output logic                    fill_err
);
    localparam int BPW   = DATA_WIDTH / 8;
    localparam int SIZE  = $clog2(BPW);
    localparam int BEATS = (1 << LINE_SIZE_BITS) / BPW;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, WAIT} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   araddr_q, araddr_d;
    logic                    arvalid_q, arvalid_d;
    logic                    rready_q, rready_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0]   mem_data_q, mem_data_d;
    logic [BPW-1:0]          mem_wstb_q, mem_wstb_d;
    logic                    mem_vld_q, mem_vld_d;
    logic                    mem_last_q, mem_last_d;
    logic                    busy_q, busy_d;
    logic                    err_q, err_d;

    assign m_axi_arlen    = 8'(BEATS - 1);
    assign m_axi_arsize   = 3'(SIZE);
    assign m_axi_arburst  = 2'b01;
    assign m_axi_araddr   = araddr_q;
    assign m_axi_arvalid  = arvalid_q;
    assign m_axi_rready   = rready_q;
    assign mem_addr       = mem_addr_q;
    assign mem_data       = mem_data_q;
    assign mem_wstb       = mem_wstb_q;
    assign mem_data_valid = mem_vld_q;
    assign mem_last       = mem_last_q;
    assign fill_busy      = busy_q;
    assign fill_err       = err_q;

    always_comb begin
        state_d    = state_q;
        araddr_d   = araddr_q;
        arvalid_d  = arvalid_q;
        rready_d   = rready_q;
        cnt_d      = cnt_q;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        mem_wstb_d = '0;
        mem_vld_d  = 1'b0;
        mem_last_d = 1'b0;
        err_d      = err_q;

        case (state_q)
            IDLE: begin
                if (miss) begin
                    araddr_d  = {miss_addr[ADDR_WIDTH-1:LINE_SIZE_BITS], {LINE_SIZE_BITS{1'b0}}};
                    arvalid_d = 1'b1;
                    err_d     = 1'b0;
                    cnt_d     = '0;
                    state_d   = ADDR;
                end
            end
            ADDR: begin
                if (arvalid_q && m_axi_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (m_axi_rvalid && rready_q) begin
                    mem_data_d = m_axi_rdata;
                    mem_addr_d = araddr_q + (ADDR_WIDTH'(cnt_q) << SIZE);
                    mem_wstb_d = '1;
                    mem_vld_d  = 1'b1;
                    mem_last_d = m_axi_rlast;
                    cnt_d      = cnt_q + 1'b1;
                    // Short burst (early rlast) and overlong burst (no rlast on final index) are both errors.
                    if (m_axi_rresp != 2'b00 || (m_axi_rlast != (cnt_q == LAST_BEAT)))
                        err_d = 1'b1;
                    if (m_axi_rlast) begin
                        rready_d = 1'b0;
                        state_d  = WAIT;
                    end
                end
            end
            WAIT: begin
                // The cache drops miss a cycle late; waiting here avoids refetching the same line.
                if (!miss)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            araddr_q   <= '0;
            arvalid_q  <= 1'b0;
            rready_q   <= 1'b0;
            cnt_q      <= '0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            mem_wstb_q <= '0;
            mem_vld_q  <= 1'b0;
            mem_last_q <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            araddr_q   <= araddr_d;
            arvalid_q  <= arvalid_d;
            rready_q   <= rready_d;
            cnt_q      <= cnt_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            mem_wstb_q <= mem_wstb_d;
            mem_vld_q  <= mem_vld_d;
            mem_last_q <= mem_last_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
        end
    end
endmodule

// File: tb/tb_axi_line_fill.sv
// Bench for axi_line_fill: table of fill scenarios plus a mid-burst reset sequence; fill words checked through a scoreboard queue.
`timescale 1ns/1ps
module tb_axi_line_fill;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        miss = 1'b0;
    logic [31:0] miss_addr = '0;
    logic [31:0] m_axi_araddr;
    logic [7:0]  m_axi_arlen;
    logic [2:0]  m_axi_arsize;
    logic [1:0]  m_axi_arburst;
    logic        m_axi_arvalid;
    logic        m_axi_arready = 1'b0;
    logic [31:0] m_axi_rdata = '0;
    logic [1:0]  m_axi_rresp = '0;
    logic        m_axi_rlast = 1'b0;
    logic        m_axi_rvalid = 1'b0;
    logic        m_axi_rready;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic [3:0]  mem_wstb;
    logic        mem_data_valid;
    logic        mem_last;
    logic        fill_busy;
    logic        fill_err;

    axi_line_fill #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .LINE_SIZE_BITS(7)) dut (
        .clk(clk), .reset_n(reset_n), .miss(miss), .miss_addr(miss_addr),
        .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
        .m_axi_arburst(m_axi_arburst), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_wstb(mem_wstb),
        .mem_data_valid(mem_data_valid), .mem_last(mem_last),
        .fill_busy(fill_busy), .fill_err(fill_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        last;
    } sb_t;

    typedef struct {
        logic [31:0] addr;
        int          ar_hold;
        int          last_idx;
        int          err_beat;
        int          gap;
        logic [31:0] exp_araddr;
        logic        exp_err;
    } vec_t;

    sb_t  sb_q[$];
    sb_t  mon_e;
    vec_t vecs[6];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (mem_data_valid) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got pulse addr %0h data %0h, expected none", mem_addr, mem_data);
            end else begin
                mon_e = sb_q.pop_front();
                check("sb_addr", mem_addr, mon_e.addr);
                check("sb_data", mem_data, mon_e.data);
                check("sb_last", mem_last, mon_e.last);
                check("sb_wstb", mem_wstb, 4'hF);
            end
        end else begin
            checks++;
            if (mem_wstb !== 4'h0 || mem_last !== 1'b0) begin
                errors++;
                $display("FAIL idle_strobe: got wstb %0h last %0b, expected 0 0", mem_wstb, mem_last);
            end
        end
    end

    task automatic send_beat(input logic [31:0] data, input logic last, input logic [1:0] resp,
                             input logic [31:0] exp_addr);
        bit acc = 0;
        m_axi_rvalid = 1'b1;
        m_axi_rdata  = data;
        m_axi_rlast  = last;
        m_axi_rresp  = resp;
        for (int k = 0; k < 40; k++) begin
            acc = m_axi_rready;
            step();
            if (acc) break;
        end
        if (acc) sb_q.push_back('{addr: exp_addr, data: data, last: last});
        else begin
            checks++;
            errors++;
            $display("FAIL rready_timeout: got rready 0, expected 1 within 40 cycles");
        end
        m_axi_rvalid = 1'b0;
        m_axi_rlast  = 1'b0;
        m_axi_rresp  = 2'b00;
    endtask

    task automatic fill(input vec_t v, input int id);
        int n = 0;
        miss = 1'b1;
        miss_addr = v.addr;
        step();
        check("ar_valid", m_axi_arvalid, 1'b1);
        check("ar_addr", m_axi_araddr, v.exp_araddr);
        check("ar_len", m_axi_arlen, 8'd31);
        check("ar_size", m_axi_arsize, 3'd2);
        check("ar_burst", m_axi_arburst, 2'd1);
        check("ar_busy", fill_busy, 1'b1);
        check("ar_err_clear", fill_err, 1'b0);
        miss_addr = ~v.addr;
        for (int k = 0; k < 40 && m_axi_arvalid; k++) begin
            n++;
            m_axi_arready = (n == v.ar_hold);
            step();
            m_axi_arready = 1'b0;
            if (m_axi_arvalid && m_axi_araddr !== v.exp_araddr)
                check("ar_stable", m_axi_araddr, v.exp_araddr);
        end
        check("ar_hold_cycles", n, v.ar_hold);
        check("data_rready", m_axi_rready, 1'b1);
        for (int i = 0; i <= v.last_idx; i++) begin
            repeat ($urandom_range(0, v.gap)) step();
            send_beat((id << 24) | i, i == v.last_idx, (i == v.err_beat) ? 2'b10 : 2'b00,
                      v.exp_araddr + 32'((i % 32) * 4));
        end
        step();
        check("sb_drain", sb_q.size(), 0);
        check("wait_err", fill_err, v.exp_err);
        check("wait_busy", fill_busy, 1'b1);
        check("wait_rready", m_axi_rready, 1'b0);
        step();
        check("wait_hold_busy", fill_busy, 1'b1);
        check("wait_no_refetch", m_axi_arvalid, 1'b0);
        miss = 1'b0;
        step();
        check("idle_busy", fill_busy, 1'b0);
        check("idle_err_sticky", fill_err, v.exp_err);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{32'h0000_1234, 3, 31, -1, 0, 32'h0000_1200, 1'b0};
        vecs[1] = '{32'hABCD_EF7F, 1, 31, -1, 5, 32'hABCD_EF00, 1'b0};
        vecs[2] = '{32'h0000_50A4, 1, 31,  5, 2, 32'h0000_5080, 1'b1};
        vecs[3] = '{32'h0000_2000, 2,  9, -1, 1, 32'h0000_2000, 1'b1};
        vecs[4] = '{32'hFFFF_FFFF, 1, 35, -1, 0, 32'hFFFF_FF80, 1'b1};
        vecs[5] = '{32'h0000_0080, 1, 31, -1, 3, 32'h0000_0080, 1'b0};

        repeat (3) step();
        check("rst_arvalid", m_axi_arvalid, 1'b0);
        check("rst_rready", m_axi_rready, 1'b0);
        check("rst_mem_vld", mem_data_valid, 1'b0);
        check("rst_busy", fill_busy, 1'b0);
        check("rst_err", fill_err, 1'b0);
        check("rst_araddr", m_axi_araddr, 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_data", mem_data, 32'h0);
        check("rst_arlen", m_axi_arlen, 8'd31);
        check("rst_arsize", m_axi_arsize, 3'd2);
        check("rst_arburst", m_axi_arburst, 2'd1);
        reset_n = 1'b1;
        repeat (2) step();

        for (int t = 0; t < 6; t++) fill(vecs[t], t);

        // Reset in the middle of a burst, on the 13th beat.
        miss = 1'b1;
        miss_addr = 32'h0000_3010;
        step();
        m_axi_arready = 1'b1;
        step();
        m_axi_arready = 1'b0;
        for (int i = 0; i < 12; i++) send_beat(32'hC000_0000 | i, 1'b0, 2'b00, 32'h0000_3000 + 32'(i * 4));
        m_axi_rvalid = 1'b1;
        m_axi_rdata  = 32'hDEAD_BEEF;
        reset_n = 1'b0;
        miss = 1'b0;
        step();
        m_axi_rvalid = 1'b0;
        check("mid_rst_arvalid", m_axi_arvalid, 1'b0);
        check("mid_rst_rready", m_axi_rready, 1'b0);
        check("mid_rst_mem_vld", mem_data_valid, 1'b0);
        check("mid_rst_busy", fill_busy, 1'b0);
        reset_n = 1'b1;
        repeat (3) step();
        check("post_rst_busy", fill_busy, 1'b0);
        check("post_rst_arvalid", m_axi_arvalid, 1'b0);
        fill('{32'h0000_3010, 2, 31, -1, 1, 32'h0000_3000, 1'b0}, 7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
